descifrador_8bits: RTL and testbench
====================================

Name: descifrador_8bits

Overview:
- Inverse (decipher) block for the team's 8-bit combinational cipher: given a ciphertext byte Y, it recovers the plaintext byte A such that f(A) = Y.
- f is not guaranteed bijective, so the block does an exhaustive sequential search over all 256 candidates.
- It reports the first matching plaintext, a found flag, an ambiguity flag and a saturating match count.
- Sits on the receive side of the cipher path, behind a valid/ready handshake on both ends.

Parameters:
- CNT_W, 4, width of match_count; the count saturates at 2^CNT_W-1.
- EARLY_EXIT, 0, when 1 the search stops at the first match; multi and match_count then report only that match (1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext byte offered.
- in_ready  out  1  block can accept a ciphertext (high only in IDLE).
- y_in  in  8  ciphertext byte.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- a_out  out  8  first (lowest) plaintext A with f(A)=Y; 0 when none found.
- found  out  1  at least one match.
- multi  out  1  two or more matches (ambiguous inverse).
- match_count  out  CNT_W  number of matches, saturating.

Behaviour:
- Forward function f(A), 8-bit:
  - p3=A7&A6, p2=A5&A4, p1=A3&A2, p0=A1&A0.
  - n2=p3|p2, n1=p2|p1, n0=p1|p0.
  - B = {2'b00, n2, n1, n0, n2, n1, n0}.
  - f(A) = (A + B) mod 256; the carry out is discarded.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; a_out=0; found=0; multi=0; match_count=0.
  - Internal candidate and stored Y are cleared.
  - Takes effect immediately, including mid-search; the search is abandoned and no result is produced.
- FSM state IDLE:
  - in_ready=1, out_valid=0.
  - On the edge where in_valid&in_ready: latch y_in, set cand=0, clear a_out, found, multi and match_count, go to SEARCH.
- FSM state SEARCH (one candidate per clock, in_ready=0):
  - If f(cand)==Y and found==0: a_out<=cand, found<=1.
  - If f(cand)==Y and found==1: multi<=1.
  - On any match, match_count increments, saturating at max.
  - Exit to DONE when cand==255 is evaluated, or when EARLY_EXIT=1 and a match occurs; otherwise cand increments.
  - cand never wraps: 255 is the last candidate evaluated.
- FSM state DONE:
  - out_valid=1; all result outputs held stable.
  - On out_valid&out_ready, go to IDLE; out_valid drops on that edge.
  - out_ready low holds DONE indefinitely.
- Latency, measured from the acceptance edge:
  - Full search: out_valid high after 256 edges.
  - EARLY_EXIT with first match at k: out_valid high after k+1 edges.
- Boundary conditions:
  - in_valid during SEARCH or DONE is not accepted (in_ready=0); the upstream holds its data.
  - Output handshake in DONE together with in_valid: the new byte is accepted at the earliest on the edge after returning to IDLE. Throughput is at most one byte per 258 cycles with a full search.
  - No match: found=0, a_out=0, multi=0, match_count=0; out_valid is still asserted.
  - Outputs are registered; there is no combinational path from in_* to out_*.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SEARCH, DONE);
  - localparams DATA_W=8 and LAST_CAND=8'hFF.
- Sub-module cifrado_fn (purely combinational, 8-bit in, 8-bit out) implements f. It is reused by the bench as the golden model.

Test Plan:
- Reset, then y_in=0x0C, EARLY_EXIT=0 -> out_valid exactly 256 edges after acceptance; a_out=0x03, found=1. multi and match_count must equal the values from an exhaustive golden model.
- y_in=0x00 -> a_out=0x00, found=1. Also check the forward model: cifrado_fn(0x0F)=0x2A and cifrado_fn(0xFF)=0x3E.
- y_in chosen by the bench as a byte outside the image of f -> found=0, a_out=0, match_count=0, out_valid still asserted.
- EARLY_EXIT=1, y_in=0x0C -> out_valid after 4 edges; a_out=0x03, match_count=1, multi=0.
- Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with a new byte -> outputs stable, in_ready=0, new byte not taken. Release out_ready -> IDLE, new byte accepted on the next edge.
- Drop rst_n at candidate 100 mid-search -> all outputs go to reset values immediately and in_ready=1. After release, a fresh search completes with the correct result.

Source files
------------

// File: rtl/descifrador_8bits_pkg.sv
// Shared definitions for the 8-bit decipher block: search FSM states and data sizes.
package descifrador_8bits_pkg;

    localparam int             DATA_W    = 8;
    localparam logic [7:0]     LAST_CAND = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/descifrador_8bits_cifrado_fn.sv
// Forward cipher f(A) = A + B mod 256, with B built from the pairwise ANDs of A.
module cifrado_fn
    import descifrador_8bits_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    output logic [DATA_W-1:0] y_o
);

    logic p3, p2, p1, p0;
    logic n2, n1, n0;
    logic [DATA_W-1:0] b;

    assign p3 = a_i[7] & a_i[6];
    assign p2 = a_i[5] & a_i[4];
    assign p1 = a_i[3] & a_i[2];
    assign p0 = a_i[1] & a_i[0];

    assign n2 = p3 | p2;
    assign n1 = p2 | p1;
    assign n0 = p1 | p0;

    assign b   = {2'b00, n2, n1, n0, n2, n1, n0};
    assign y_o = a_i + b;

endmodule

// File: rtl/descifrador_8bits.sv
// Exhaustive inverse of cifrado_fn: scans all 256 plaintexts, one per clock.
// Handshakes: a transfer happens on a rising edge where valid && ready; input ready only in IDLE.
module descifrador_8bits
    import descifrador_8bits_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        y_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        a_out,
    output logic              found,
    output logic              multi,
    output logic [CNT_W-1:0]  match_count,
    output state_e            dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [7:0]        cand_q, cand_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        a_q, a_d;
    logic              found_q, found_d;
    logic              multi_q, multi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        f_cand;
    logic              match;

    cifrado_fn u_fn (
        .a_i (cand_q),
        .y_o (f_cand)
    );

    assign match = (f_cand == y_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        y_d     = y_q;
        a_d     = a_q;
        found_d = found_q;
        multi_d = multi_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = y_in;
                    cand_d  = '0;
                    a_d     = '0;
                    found_d = 1'b0;
                    multi_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    if (!found_q) begin
                        a_d     = cand_q;
                        found_d = 1'b1;
                    end else begin
                        multi_d = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
                // Candidate 255 is the last one; the counter never wraps back to 0.
                if ((cand_q == LAST_CAND) || (EARLY_EXIT && match)) begin
                    state_d = DONE;
                end else begin
                    cand_d = cand_q + 8'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            y_q     <= '0;
            a_q     <= '0;
            found_q <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            y_q     <= y_d;
            a_q     <= a_d;
            found_q <= found_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign a_out       = a_q;
    assign found       = found_q;
    assign multi       = multi_q;
    assign match_count = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_descifrador_8bits.sv
// Directed bench for descifrador_8bits: a full-search instance and an early-exit instance.
module tb_descifrador_8bits;
    import descifrador_8bits_pkg::*;

    localparam int CNT_W = 4;
    localparam int EW    = 10 + CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [1:0]       in_valid_v  = '0;
    logic [1:0]       out_ready_v = '0;
    logic [1:0][7:0]  y_in_v      = '0;
    wire  [1:0]       in_ready_v;
    wire  [1:0]       out_valid_v;
    wire  [1:0]       found_v;
    wire  [1:0]       multi_v;
    wire  [1:0][7:0]  a_out_v;
    wire  [1:0][CNT_W-1:0] cnt_v;
    state_e           dbg0, dbg1;

    logic [7:0] g_a = '0;
    logic [7:0] g_y;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int cnt_tab[256];
    int first_tab[256];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    logic [7:0]    no_img;
    bit            no_img_ok;

    always #5 clk = ~clk;

    descifrador_8bits #(.CNT_W(CNT_W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .y_in(y_in_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .a_out(a_out_v[0]), .found(found_v[0]), .multi(multi_v[0]),
        .match_count(cnt_v[0]), .dbg_state_o(dbg0)
    );

    descifrador_8bits #(.CNT_W(CNT_W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .y_in(y_in_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .a_out(a_out_v[1]), .found(found_v[1]), .multi(multi_v[1]),
        .match_count(cnt_v[1]), .dbg_state_o(dbg1)
    );

    cifrado_fn u_golden (.a_i(g_a), .y_o(g_y));

    // Independent transcription of f, used to cross-check the golden instance.
    function automatic logic [7:0] f_ref(input logic [7:0] a);
        logic q3, q2, q1, q0, m2, m1, m0;
        q3 = a[7] & a[6]; q2 = a[5] & a[4]; q1 = a[3] & a[2]; q0 = a[1] & a[0];
        m2 = q3 | q2; m1 = q2 | q1; m0 = q1 | q0;
        return a + {2'b00, m2, m1, m0, m2, m1, m0};
    endfunction

    function automatic logic [EW-1:0] mk_exp(input logic [7:0] y, input bit ee);
        int          c;
        logic        f, m;
        logic [7:0]  a;
        int          first;
        logic [CNT_W-1:0] cc;
        c     = cnt_tab[y];
        first = first_tab[y];
        f     = (c > 0);
        a     = f ? first[7:0] : 8'h00;
        if (ee) begin
            m  = 1'b0;
            cc = f ? CNT_W'(1) : CNT_W'(0);
        end else begin
            m  = (c >= 2);
            cc = (c > 15) ? CNT_W'(15) : CNT_W'(c);
        end
        return {a, f, m, cc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready_v[0],  1);
        check({tag, "_out_valid"}, out_valid_v[0], 0);
        check({tag, "_a_out"},     a_out_v[0],     0);
        check({tag, "_found"},     found_v[0],     0);
        check({tag, "_multi"},     multi_v[0],     0);
        check({tag, "_count"},     cnt_v[0],       0);
    endtask

    task automatic accept_byte(input logic [7:0] y, input bit ee);
        sel = ee ? 1 : 0;
        check("idle_in_ready", in_ready_v[sel], 1);
        in_valid_v[sel] = 1'b1;
        y_in_v[sel]     = y;
        @(posedge clk); #1;
        check("accepted_in_ready_low", in_ready_v[sel], 0);
        in_valid_v[sel] = 1'b0;
        exp_q.push_back(mk_exp(y, ee));
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 0;
        while (out_valid_v[sel] !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            last_exp = exp_q.pop_front();
            check({tag, "_a_out"}, a_out_v[sel], last_exp[EW-1 -: 8]);
            check({tag, "_found"}, found_v[sel], last_exp[CNT_W+1]);
            check({tag, "_multi"}, multi_v[sel], last_exp[CNT_W]);
            check({tag, "_count"}, cnt_v[sel],   last_exp[CNT_W-1:0]);
        end
    endtask

    task automatic release_out(input string tag);
        out_ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, out_valid_v[sel], 0);
        check({tag, "_back_idle"},      in_ready_v[sel],  1);
        out_ready_v[sel] = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;

        for (int i = 0; i < 256; i++) begin
            cnt_tab[i]   = 0;
            first_tab[i] = 0;
        end
        for (int a = 0; a < 256; a++) begin
            g_a = 8'(a);
            #1;
            check("fwd_model", g_y, f_ref(8'(a)));
            if (cnt_tab[g_y] == 0) first_tab[g_y] = a;
            cnt_tab[g_y]++;
        end
        g_a = 8'h0F; #1;
        check("fn_0F", g_y, 8'h2A);
        g_a = 8'hFF; #1;
        check("fn_FF", g_y, 8'h3E);

        no_img_ok = 1'b0;
        no_img    = 8'h00;
        for (int y = 255; y >= 0; y--) begin
            if (cnt_tab[y] == 0) begin
                no_img    = 8'(y);
                no_img_ok = 1'b1;
            end
        end
        check("unreached_byte_exists", no_img_ok, 1);

        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        accept_byte(8'h0C, 1'b0);
        wait_result("y0C", 256);
        check("y0C_a_const", a_out_v[0], 8'h03);
        check("y0C_found_const", found_v[0], 1);
        release_out("y0C");

        accept_byte(8'h00, 1'b0);
        wait_result("y00", 256);
        check("y00_found_const", found_v[0], 1);
        release_out("y00");

        accept_byte(8'h2A, 1'b0);
        wait_result("y2A", 256);
        check("y2A_multi_const", multi_v[0], 1);
        release_out("y2A");

        accept_byte(no_img, 1'b0);
        wait_result("no_image", 256);
        check("no_image_out_valid", out_valid_v[0], 1);
        check("no_image_found_const", found_v[0], 0);
        release_out("no_image");

        accept_byte(8'h0C, 1'b1);
        wait_result("ee_y0C", 4);
        check("ee_a_const", a_out_v[1], 8'h03);
        check("ee_count_const", cnt_v[1], 1);
        check("ee_multi_const", multi_v[1], 0);
        release_out("ee_y0C");

        accept_byte(8'h55, 1'b0);
        wait_result("y55", 256);
        in_valid_v[0] = 1'b1;
        y_in_v[0]     = 8'h0C;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid_v[0], 1);
            check("hold_in_ready",  in_ready_v[0],  0);
            check("hold_a_out",     a_out_v[0], last_exp[EW-1 -: 8]);
            check("hold_count",     cnt_v[0],   last_exp[CNT_W-1:0]);
        end
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        check("hold_release_out_valid", out_valid_v[0], 0);
        check("hold_release_in_ready",  in_ready_v[0],  1);
        out_ready_v[0] = 1'b0;
        @(posedge clk); #1;
        check("hold_new_byte_taken", in_ready_v[0], 0);
        in_valid_v[0] = 1'b0;
        exp_q.push_back(mk_exp(8'h0C, 1'b0));
        wait_result("after_hold", 256);
        release_out("after_hold");

        accept_byte(8'h2A, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        check("pre_reset_found", found_v[0], 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        void'(exp_q.pop_back());
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        accept_byte(8'h2A, 1'b0);
        wait_result("post_reset", 256);
        release_out("post_reset");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
